// File: rtl/gold_reader.sv
// UART command initiator: sends CMD_BYTE, then captures NUM_BYTES reply bytes with an inter-byte timeout.
// Optional feature macro: GOLD_READER_CHECK_EN adds a `match` output comparing the capture against "A".."P".
module gold_reader #(
  parameter int unsigned NUM_BYTES      = 16,
  parameter logic [7:0]  CMD_BYTE       = 8'h67,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [4:0] byte_count,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
`ifdef GOLD_READER_CHECK_EN
  ,
  output logic       match
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } state_t;

  localparam logic [4:0]  LAST_IDX   = 5'(NUM_BYTES - 1);
  localparam logic [31:0] TMR_LAST   = TIMEOUT_CYCLES - 32'd1;
  // Addresses at or beyond NUM_BYTES read back as zero.
  localparam logic [15:0] VALID_MASK = 16'((17'd1 << NUM_BYTES) - 17'd1);

  state_t      state_q, state_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        buf_we;
  logic [7:0]  buf_q [16];

`ifdef GOLD_READER_CHECK_EN
  logic ok_q, ok_d;
  logic match_q, match_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    count_d   = count_q;
    tmr_d     = tmr_q;
    buf_we    = 1'b0;
`ifdef GOLD_READER_CHECK_EN
    ok_d      = ok_q;
    match_d   = match_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          count_d   = 5'd0;
          timeout_d = 1'b0;
`ifdef GOLD_READER_CHECK_EN
          ok_d      = 1'b1;
          match_d   = 1'b0;
`endif
        end
      end
      SEND: begin
        if (tx_rdy) begin
          tx_en_d   = 1'b1;
          tx_data_d = CMD_BYTE;
          tmr_d     = 32'd0;
          state_d   = RECV;
        end
      end
      RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          buf_we  = 1'b1;
          count_d = count_q + 5'd1;
          tmr_d   = 32'd0;
`ifdef GOLD_READER_CHECK_EN
          ok_d    = ok_q & (rx_data == (8'h41 + {3'b000, count_q}));
`endif
          if (count_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef GOLD_READER_CHECK_EN
            match_d = ok_d;
`endif
          end
        end else if (tmr_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_data_d = VALID_MASK[rd_addr] ? buf_q[rd_addr] : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= 5'd0;
      tmr_q     <= 32'd0;
      rd_data_q <= 8'h00;
`ifdef GOLD_READER_CHECK_EN
      ok_q      <= 1'b0;
      match_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      tmr_q     <= tmr_d;
      rd_data_q <= rd_data_d;
`ifdef GOLD_READER_CHECK_EN
      ok_q      <= ok_d;
      match_q   <= match_d;
`endif
    end
  end

  // NOTE: the capture buffer is deliberately left out of reset so it maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[count_q[3:0]] <= rx_data;
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign byte_count = count_q;
  assign rd_data    = rd_data_q;
`ifdef GOLD_READER_CHECK_EN
  assign match      = match_q;
`endif

endmodule

// File: tb/tb_gold_reader.sv
// Randomized self-checking bench for gold_reader against a transaction-level model of a fetch.
// Build with GOLD_READER_CHECK_EN defined to also check the match output.
module tb_gold_reader;

  localparam int         NB  = 16;
  localparam int         T   = 100;
  localparam logic [7:0] CMD = 8'h67;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       tx_rdy = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] rd_addr = 4'd0;
  logic       tx_en, busy, done, timeout;
  logic [7:0] tx_data, rd_data;
  logic [4:0] byte_count;
`ifdef GOLD_READER_CHECK_EN
  logic       match;
`endif

  gold_reader #(
    .NUM_BYTES     (NB),
    .CMD_BYTE      (CMD),
    .TIMEOUT_CYCLES(32'(T))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_rdy    (tx_rdy),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .byte_count(byte_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`ifdef GOLD_READER_CHECK_EN
    ,
    .match     (match)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for a request, 1 = command pending, 2 = collecting reply.
  int         mode = 0;
  int         quiet = 0;
  logic [7:0] m_buf [NB];
  bit         m_known [NB];
  logic       e_tx_en = 1'b0, e_done = 1'b0, e_timeout = 1'b0, e_match = 1'b0;
  logic [7:0] e_tx_data = 8'h00, e_rd_data = 8'h00;
  bit         e_rd_known = 1'b1;
  int         e_count = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; quiet = 0; e_count = 0;
      e_tx_en = 0; e_tx_data = 8'h00; e_done = 0; e_timeout = 0; e_match = 0;
      e_rd_data = 8'h00; e_rd_known = 1;
    end else begin
      // Read sees the buffer as it was before any write on this edge.
      if (int'(rd_addr) >= NB) begin
        e_rd_known = 1; e_rd_data = 8'h00;
      end else begin
        e_rd_known = m_known[rd_addr]; e_rd_data = m_buf[rd_addr];
      end
      e_tx_en = 0;
      e_done  = 0;
      if (mode == 0) begin
        if (start) begin
          mode = 1; e_count = 0; e_timeout = 0; e_match = 0;
        end
      end else if (mode == 1) begin
        if (tx_rdy) begin
          e_tx_en = 1; e_tx_data = CMD; quiet = 0; mode = 2;
        end
      end else begin
        if (rx_valid) begin
          m_buf[e_count] = rx_data;
          m_known[e_count] = 1;
          e_count++;
          quiet = 0;
          if (e_count == NB) begin
            e_done = 1; mode = 0; e_match = 1;
            for (int i = 0; i < NB; i++)
              if (m_buf[i] != 8'(8'h41 + i)) e_match = 0;
          end
        end else begin
          quiet++;
          if (quiet == T) begin
            e_timeout = 1; mode = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("tx_en", 32'(tx_en), 32'(e_tx_en));
    check("tx_data", 32'(tx_data), 32'(e_tx_data));
    check("busy", 32'(busy), 32'(mode != 0));
    check("done", 32'(done), 32'(e_done));
    check("timeout", 32'(timeout), 32'(e_timeout));
    check("byte_count", 32'(byte_count), 32'(e_count));
    if (e_rd_known) check("rd_data", 32'(rd_data), 32'(e_rd_data));
`ifdef GOLD_READER_CHECK_EN
    check("match", 32'(match), 32'(e_match));
`endif
  end

  // ---------------- stimulus ----------------
  bit rd_hold = 1'b0;

  always @(posedge clk) begin
    #2;
    if (!rd_hold) rd_addr = 4'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_tx();
    for (int k = 0; k < 200; k++) begin
      if (tx_en) break;
      tick();
    end
    check("tx_en_seen", 32'(tx_en), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      tick();
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [7:0] exp, input string name);
    rd_hold = 1'b1;
    rd_addr = a;
    tick();
    check(name, 32'(rd_data), 32'(exp));
    rd_hold = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    tick();

    // Normal fetch of "A".."P".
    tx_rdy = 1'b1;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    wait_tx();
    check("cmd_byte", 32'(tx_data), 32'h67);
    for (int i = 0; i < NB; i++) send_byte(8'(8'h41 + i), $urandom_range(0, 4));
    check("done_pulse", 32'(done), 32'd1);
    check("count_full", 32'(byte_count), 32'd16);
`ifdef GOLD_READER_CHECK_EN
    check("match_good", 32'(match), 32'd1);
`endif
    for (int a = 0; a < NB; a++) read_lit(4'(a), 8'(8'h41 + a), "rd_normal");

    // Transmitter busy for 50 cycles.
    tx_rdy = 1'b0;
    pulse_start();
    repeat (50) begin
      check("tx_en_held", 32'(tx_en), 32'd0);
      tick();
    end
    tx_rdy = 1'b1;
    tick();
    check("tx_en_after_rdy", 32'(tx_en), 32'd1);
    tick();
    check("tx_en_one_cycle", 32'(tx_en), 32'd0);
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), $urandom_range(0, 3));
    wait_idle();

    // Timeout after 5 bytes, then a stray byte in idle, then restart.
    pulse_start();
    wait_tx();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), $urandom_range(0, 3));
    for (k = 1; k <= 300; k++) begin
      tick();
      if (timeout) break;
    end
    check("timeout_latency", 32'(k), 32'd100);
    check("timeout_count", 32'(byte_count), 32'd5);
    send_byte(8'hEE, 2);
    check("idle_rx_ignored", 32'(byte_count), 32'd5);
    pulse_start();
    check("timeout_cleared", 32'(timeout), 32'd0);
    wait_tx();
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    wait_idle();

    // Expiry collisions: on entry to RECV and between bytes.
    pulse_start();
    wait_tx();
    send_byte(8'h41, T - 1);
    send_byte(8'h42, T - 1);
    check("collision_no_timeout", 32'(timeout), 32'd0);
    check("collision_count", 32'(byte_count), 32'd2);
    for (int i = 2; i < NB; i++) send_byte(8'(8'h41 + i), $urandom_range(0, 2));
    check("collision_done", 32'(done), 32'd1);

    // Back-to-back start, with byte 3 corrupted.
    pulse_start();
    check("b2b_accepted", 32'(busy), 32'd1);
    wait_tx();
    for (int i = 0; i < NB; i++) send_byte((i == 3) ? 8'h58 : 8'(8'h41 + i), $urandom_range(0, 2));
    check("mismatch_done", 32'(done), 32'd1);
`ifdef GOLD_READER_CHECK_EN
    check("match_bad", 32'(match), 32'd0);
`endif
    read_lit(4'd3, 8'h58, "rd_mismatch");

    // Start pulses while receiving, reset after the 8th byte.
    pulse_start();
    wait_tx();
    for (int i = 0; i < 8; i++) begin
      start = (i % 2 == 0);
      send_byte(8'(8'h41 + i), $urandom_range(0, 2));
    end
    start = 1'b0;
    check("recv_start_ignored", 32'(byte_count), 32'd8);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(byte_count), 32'd0);
    rst = 1'b0;
    tick();
    read_lit(4'd2, 8'h43, "buf_survives_rst");

    // Randomized fetches.
    for (int f = 0; f < 25; f++) begin
      bit pattern;
      int r;
      pattern = 1'($urandom);
      tx_rdy = 1'b0;
      pulse_start();
      repeat ($urandom_range(0, 5)) tick();
      tx_rdy = 1'b1;
      wait_tx();
      for (int i = 0; i < NB; i++) begin
        r = $urandom_range(0, 29);
        start = ($urandom_range(0, 7) == 0);
        if (r == 1) begin
          repeat (T + 3) tick();
          break;
        end
        send_byte(pattern ? 8'(8'h41 + i) : 8'($urandom), (r == 0) ? T - 1 : $urandom_range(0, 6));
      end
      start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, required completion before 900000");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
